// File: rtl/v_pipe_query_walker.sv
// ---------------------------------------------------------------------------
// v_pipe_query_walker
//
// Query-bus initiator that dumps one product's list. A command latches the
// product ID, then levels 0..ENTRIES_N-1 are queried one at a time against a
// lookup pipeline that answers exactly one cycle after each query. Errored
// answers (busy / invalid level) are re-queried after a backoff. A level that
// keeps failing is skipped once its retries run out. Valid entries leave
// over a valid/ready stream. A one-cycle done pulse reports status and count.
//
// Ports
//   clk, arst_n            clock, asynchronous active-low reset
//   init_r                 table initialisation running; blocks new commands
//   i_cmd_vld / o_cmd_rdy  dump command handshake, i_cmd_prod_id = product
//   o_lut_vld/_prod_id/_level      query issue (never two cycles in a row)
//   i_lut_vld_r/_key/_size/_error/_listsize  response, one cycle after issue
//   o_ent_vld / i_ent_rdy  entry stream, o_ent_level/_key/_size payload
//   o_done_vld             single-cycle end-of-walk pulse
//   o_done_status          0 = OK, 1 = NORSP (missing response)
//   o_done_count           entries emitted in the last walk
//
// Width parameters stand in for the shared list types: ID_W (product ID),
// KEY_W (key), VOL_W (volume). Level and listsize widths follow ENTRIES_N.
// ---------------------------------------------------------------------------
module v_pipe_query_walker #(
  parameter int  ENTRIES_N   = 8,
  parameter int  RETRY_MAX   = 3,
  parameter int  BACKOFF_CYC = 5,
  parameter int  ID_W        = 8,
  parameter int  KEY_W       = 16,
  parameter int  VOL_W       = 16,
  localparam int LEVEL_W     = (ENTRIES_N > 1) ? $clog2(ENTRIES_N) : 1,
  localparam int LS_W        = $clog2(ENTRIES_N + 1)
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               init_r,
  input  logic               i_cmd_vld,
  input  logic [ID_W-1:0]    i_cmd_prod_id,
  output logic               o_cmd_rdy,
  output logic               o_lut_vld,
  output logic [ID_W-1:0]    o_lut_prod_id,
  output logic [LEVEL_W-1:0] o_lut_level,
  input  logic               i_lut_vld_r,
  input  logic [KEY_W-1:0]   i_lut_key,
  input  logic [VOL_W-1:0]   i_lut_size,
  input  logic               i_lut_error,
  input  logic [LS_W-1:0]    i_lut_listsize,
  output logic               o_ent_vld,
  input  logic               i_ent_rdy,
  output logic [LEVEL_W-1:0] o_ent_level,
  output logic [KEY_W-1:0]   o_ent_key,
  output logic [VOL_W-1:0]   o_ent_size,
  output logic               o_done_vld,
  output logic [1:0]         o_done_status,
  output logic [LS_W-1:0]    o_done_count
);

  // Level counter carries one extra bit so stepping past the last level is
  // visible as a value >= ENTRIES_N instead of silently wrapping to 0.
  localparam int LVC_W = LEVEL_W + 1;
  localparam int RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int BO_W  = (BACKOFF_CYC > 0) ? $clog2(BACKOFF_CYC + 1) : 1;

  localparam logic [LVC_W-1:0] LEVEL_END   = LVC_W'(ENTRIES_N);
  localparam logic [RTY_W-1:0] RETRY_LIM   = RTY_W'(RETRY_MAX);
  // BACKOFF always lasts at least one cycle, even with BACKOFF_CYC = 0.
  localparam logic [BO_W-1:0]  BO_LAST     = (BACKOFF_CYC > 0) ? BO_W'(BACKOFF_CYC - 1) : '0;
  localparam logic [LS_W-1:0]  TARGET_INIT = LS_W'(ENTRIES_N);
  localparam logic [1:0]       STAT_NORSP  = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF, S_EMIT, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    prod_id_reg;
  logic [LVC_W-1:0]   level_reg;
  logic [RTY_W-1:0]   retry_reg;
  logic [BO_W-1:0]    backoff_reg;
  logic [LS_W-1:0]    count_reg;
  logic [LS_W-1:0]    target_reg;
  logic [1:0]         status_reg;
  logic [LEVEL_W-1:0] ent_level_reg;
  logic [KEY_W-1:0]   ent_key_reg;
  logic [VOL_W-1:0]   ent_size_reg;

  logic               cmd_fire;
  logic [LVC_W-1:0]   level_inc;
  logic [LS_W-1:0]    count_inc;
  logic               level_wrap;
  logic               retry_ok;
  logic               skip_end;
  logic               emit_end;

  // Shared decision terms. skip_end / emit_end are the NEXT decision taken
  // after a skipped level and after an emitted entry respectively; both use
  // the already-advanced level and (for emit) the already-incremented count.
  always_comb begin
    cmd_fire   = (state_reg == S_IDLE) && !init_r && i_cmd_vld;
    level_inc  = level_reg + LVC_W'(1);
    count_inc  = count_reg + LS_W'(1);
    level_wrap = (level_inc >= LEVEL_END);
    retry_ok   = (retry_reg < RETRY_LIM);
    skip_end   = level_wrap || (count_reg >= target_reg);
    emit_end   = level_wrap || (count_inc >= target_reg);
  end

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (cmd_fire) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_WAIT;
      S_WAIT: begin
        if (!i_lut_vld_r)     state_next = S_DONE;
        else if (i_lut_error) state_next = retry_ok ? S_BACKOFF : (skip_end ? S_DONE : S_ISSUE);
        else                  state_next = S_EMIT;
      end
      S_BACKOFF: if (backoff_reg == BO_LAST) state_next = S_ISSUE;
      S_EMIT:    if (i_ent_rdy) state_next = emit_end ? S_DONE : S_ISSUE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_cmd_rdy  = 1'b0;
    o_lut_vld  = 1'b0;
    o_ent_vld  = 1'b0;
    o_done_vld = 1'b0;
    case (state_reg)
      S_IDLE:  o_cmd_rdy  = !init_r;
      S_ISSUE: o_lut_vld  = 1'b1;
      S_EMIT:  o_ent_vld  = 1'b1;
      S_DONE:  o_done_vld = 1'b1;
      default: ;
    endcase
  end

  // Walk bookkeeping and entry holding registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      prod_id_reg   <= '0;
      level_reg     <= '0;
      retry_reg     <= '0;
      backoff_reg   <= '0;
      count_reg     <= '0;
      target_reg    <= '0;
      status_reg    <= '0;
      ent_level_reg <= '0;
      ent_key_reg   <= '0;
      ent_size_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_fire) begin
            prod_id_reg <= i_cmd_prod_id;
            level_reg   <= '0;
            retry_reg   <= '0;
            count_reg   <= '0;
            target_reg  <= TARGET_INIT;
            status_reg  <= '0;
          end
        end
        S_WAIT: begin
          if (!i_lut_vld_r) begin
            status_reg <= STAT_NORSP;
          end else if (i_lut_error) begin
            // Error answers never touch target: their listsize is not trusted.
            if (retry_ok) begin
              retry_reg   <= retry_reg + RTY_W'(1);
              backoff_reg <= '0;
            end else begin
              level_reg <= level_inc;
              retry_reg <= '0;
            end
          end else begin
            ent_level_reg <= level_reg[LEVEL_W-1:0];
            ent_key_reg   <= i_lut_key;
            ent_size_reg  <= i_lut_size;
            target_reg    <= i_lut_listsize;
          end
        end
        S_BACKOFF: backoff_reg <= backoff_reg + BO_W'(1);
        S_EMIT: begin
          if (i_ent_rdy) begin
            count_reg <= count_inc;
            level_reg <= level_inc;
            retry_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_lut_prod_id = prod_id_reg;
  assign o_lut_level   = level_reg[LEVEL_W-1:0];
  assign o_ent_level   = ent_level_reg;
  assign o_ent_key     = ent_key_reg;
  assign o_ent_size    = ent_size_reg;
  assign o_done_status = status_reg;
  assign o_done_count  = count_reg;

endmodule

// File: tb/tb_v_pipe_query_walker.sv
// ---------------------------------------------------------------------------
// Directed bench for v_pipe_query_walker (ENTRIES_N=8, RETRY_MAX=3,
// BACKOFF_CYC=5). Everything runs in one initial block: step() advances to the
// next falling edge, plays the one-cycle-latency lookup responder from a small
// per-level table and tracks protocol observations. Expected cycle numbers are
// relative to the cycle in which the command is presented (T).
// ---------------------------------------------------------------------------
module tb_v_pipe_query_walker;

  logic        clk;
  logic        arst_n;
  logic        init_r;
  logic        i_cmd_vld;
  logic [7:0]  i_cmd_prod_id;
  logic        o_cmd_rdy;
  logic        o_lut_vld;
  logic [7:0]  o_lut_prod_id;
  logic [2:0]  o_lut_level;
  logic        i_lut_vld_r;
  logic [15:0] i_lut_key;
  logic [15:0] i_lut_size;
  logic        i_lut_error;
  logic [3:0]  i_lut_listsize;
  logic        o_ent_vld;
  logic        i_ent_rdy;
  logic [2:0]  o_ent_level;
  logic [15:0] o_ent_key;
  logic [15:0] o_ent_size;
  logic        o_done_vld;
  logic [1:0]  o_done_status;
  logic [3:0]  o_done_count;

  v_pipe_query_walker dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .init_r         (init_r),
    .i_cmd_vld      (i_cmd_vld),
    .i_cmd_prod_id  (i_cmd_prod_id),
    .o_cmd_rdy      (o_cmd_rdy),
    .o_lut_vld      (o_lut_vld),
    .o_lut_prod_id  (o_lut_prod_id),
    .o_lut_level    (o_lut_level),
    .i_lut_vld_r    (i_lut_vld_r),
    .i_lut_key      (i_lut_key),
    .i_lut_size     (i_lut_size),
    .i_lut_error    (i_lut_error),
    .i_lut_listsize (i_lut_listsize),
    .o_ent_vld      (o_ent_vld),
    .i_ent_rdy      (i_ent_rdy),
    .o_ent_level    (o_ent_level),
    .o_ent_key      (o_ent_key),
    .o_ent_size     (o_ent_size),
    .o_done_vld     (o_done_vld),
    .o_done_status  (o_done_status),
    .o_done_count   (o_done_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // responder model
  int          err_n [8];      // number of leading error answers per level (255 = always)
  int          qcnt  [8];      // queries seen per level
  logic [15:0] key_tab  [8];
  logic [15:0] size_tab [8];
  logic [3:0]  resp_listsize;
  logic        suppress;
  logic        pend;
  logic [2:0]  plvl;
  int          pidx;
  logic [7:0]  last_id;
  int          qcyc [16];
  logic [2:0]  qlvl [16];
  int          nq;
  // protocol observation
  int          viol;
  int          ndone;
  logic        prev_lut_vld, prev_ent_vld;
  logic [2:0]  prev_lvl;
  logic [15:0] prev_key, prev_size;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    // stream data must hold while a stalled entry is pending
    if (arst_n && prev_ent_vld && !i_ent_rdy &&
        (!o_ent_vld || o_ent_level != prev_lvl || o_ent_key != prev_key || o_ent_size != prev_size))
      viol++;
    if (o_lut_vld && prev_lut_vld) viol++;
    if (o_done_vld) ndone++;
    // answer the query issued in the previous cycle
    i_lut_vld_r    = 1'b0;
    i_lut_error    = 1'b0;
    i_lut_key      = '0;
    i_lut_size     = '0;
    i_lut_listsize = '0;
    if (pend && arst_n) begin
      i_lut_vld_r = !suppress;
      if (pidx < err_n[plvl]) begin
        i_lut_error    = 1'b1;
        i_lut_listsize = 4'd1;   // garbage listsize on errors must be ignored
      end else begin
        i_lut_key      = key_tab[plvl];
        i_lut_size     = size_tab[plvl];
        i_lut_listsize = resp_listsize;
      end
    end
    pend = o_lut_vld && arst_n;
    if (o_lut_vld) begin
      plvl = o_lut_level;
      pidx = qcnt[plvl];
      qcnt[plvl]++;
      last_id = o_lut_prod_id;
      if (nq < 16) begin
        qcyc[nq] = cyc;
        qlvl[nq] = o_lut_level;
      end
      nq++;
    end
    prev_lut_vld = o_lut_vld;
    prev_ent_vld = o_ent_vld;
    prev_lvl     = o_ent_level;
    prev_key     = o_ent_key;
    prev_size    = o_ent_size;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      qcnt[i]     = 0;
      err_n[i]    = 0;
      key_tab[i]  = '0;
      size_tab[i] = '0;
    end
    nq    = 0;
    viol  = 0;
    ndone = 0;
  endtask

  task automatic send_cmd(input logic [7:0] id, output int t0);
    int n = 0;
    while (!o_cmd_rdy && n < 20) begin
      step();
      n++;
    end
    chk("cmd_rdy_wait", 32'(o_cmd_rdy), 32'd1);
    i_cmd_vld     = 1'b1;
    i_cmd_prod_id = id;
    t0            = cyc;
    step();
    i_cmd_vld     = 1'b0;
  endtask

  task automatic wait_ent(output logic got, output int at, output logic [2:0] lvl,
                          output logic [15:0] key, output logic [15:0] size);
    got = 1'b0; at = -1; lvl = '0; key = '0; size = '0;
    for (int n = 0; n < 80 && !got; n++) begin
      if (o_ent_vld && i_ent_rdy) begin
        got = 1'b1; at = cyc; lvl = o_ent_level; key = o_ent_key; size = o_ent_size;
      end
      step();
    end
  endtask

  task automatic wait_done(output logic got, output int at, output logic [1:0] st,
                           output logic [3:0] cnt);
    got = 1'b0; at = -1; st = '0; cnt = '0;
    for (int n = 0; n < 80 && !got; n++) begin
      if (o_done_vld) begin
        got = 1'b1; at = cyc; st = o_done_status; cnt = o_done_count;
      end else begin
        step();
      end
    end
  endtask

  initial begin
    int          t0, t1, at, nq0;
    logic        got;
    logic [2:0]  lvl;
    logic [15:0] key, size;
    logic [1:0]  st;
    logic [3:0]  cnt;

    arst_n = 1'b0; init_r = 1'b0; i_cmd_vld = 1'b0; i_cmd_prod_id = '0;
    i_lut_vld_r = 1'b0; i_lut_key = '0; i_lut_size = '0; i_lut_error = 1'b0;
    i_lut_listsize = '0; i_ent_rdy = 1'b1;
    suppress = 1'b0; pend = 1'b0; plvl = '0; pidx = 0; last_id = '0;
    prev_lut_vld = 1'b0; prev_ent_vld = 1'b0; prev_lvl = '0; prev_key = '0; prev_size = '0;
    resp_listsize = '0;
    for (int i = 0; i < 16; i++) begin qcyc[i] = 0; qlvl[i] = '0; end
    clear_model();

    // ---------------- reset state ----------------
    run(2);
    chk("rst_cmd_rdy", 32'(o_cmd_rdy), 32'd1);
    chk("rst_lut_vld", 32'(o_lut_vld), 32'd0);
    chk("rst_lut_id", 32'(o_lut_prod_id), 32'd0);
    chk("rst_lut_level", 32'(o_lut_level), 32'd0);
    chk("rst_ent_vld", 32'(o_ent_vld), 32'd0);
    chk("rst_ent_key", 32'(o_ent_key), 32'd0);
    chk("rst_done_vld", 32'(o_done_vld), 32'd0);
    chk("rst_done_cnt", 32'(o_done_count), 32'd0);
    init_r = 1'b1;
    #1;
    chk("rst_rdy_init", 32'(o_cmd_rdy), 32'd0);
    init_r = 1'b0;
    step();
    arst_n = 1'b1;
    step();

    // ---------------- 1: three clean entries ----------------
    clear_model();
    key_tab[0] = 16'h1234; size_tab[0] = 16'd10;
    key_tab[1] = 16'h5678; size_tab[1] = 16'd20;
    key_tab[2] = 16'h9ABC; size_tab[2] = 16'd30;
    resp_listsize = 4'd3;
    send_cmd(8'h5A, t0);
    wait_ent(got, at, lvl, key, size);
    chk("t1_e0_got", 32'(got), 32'd1);
    chk("t1_e0_at", 32'(at), 32'(t0 + 3));
    chk("t1_e0_lvl", 32'(lvl), 32'd0);
    chk("t1_e0_key", 32'(key), 32'h1234);
    chk("t1_e0_size", 32'(size), 32'd10);
    wait_ent(got, at, lvl, key, size);
    chk("t1_e1_at", 32'(at), 32'(t0 + 6));
    chk("t1_e1_lvl", 32'(lvl), 32'd1);
    chk("t1_e1_key", 32'(key), 32'h5678);
    wait_ent(got, at, lvl, key, size);
    chk("t1_e2_at", 32'(at), 32'(t0 + 9));
    chk("t1_e2_lvl", 32'(lvl), 32'd2);
    chk("t1_e2_size", 32'(size), 32'd30);
    wait_done(got, at, st, cnt);
    chk("t1_done_at", 32'(at), 32'(t0 + 10));
    chk("t1_done_st", 32'(st), 32'd0);
    chk("t1_done_cnt", 32'(cnt), 32'd3);
    chk("t1_qid", 32'(last_id), 32'h5A);
    chk("t1_nq", 32'(nq), 32'd3);
    chk("t1_viol", 32'(viol), 32'd0);
    step();
    chk("t1_pulse_end", 32'(o_done_vld), 32'd0);
    chk("t1_cnt_hold", 32'(o_done_count), 32'd3);
    chk("t1_rdy_back", 32'(o_cmd_rdy), 32'd1);

    // ---------------- 2: level 0 busy twice ----------------
    clear_model();
    err_n[0] = 2; key_tab[0] = 16'hBEEF; size_tab[0] = 16'd77;
    resp_listsize = 4'd1;
    send_cmd(8'h11, t0);
    wait_ent(got, at, lvl, key, size);
    chk("t2_e_at", 32'(at), 32'(t0 + 17));
    chk("t2_e_key", 32'(key), 32'hBEEF);
    wait_done(got, at, st, cnt);
    chk("t2_done_at", 32'(at), 32'(t0 + 18));
    chk("t2_done_cnt", 32'(cnt), 32'd1);
    chk("t2_nq", 32'(nq), 32'd3);
    chk("t2_q0", 32'(qcyc[0]), 32'(t0 + 1));
    chk("t2_q1", 32'(qcyc[1]), 32'(t0 + 8));
    chk("t2_q2", 32'(qcyc[2]), 32'(t0 + 15));
    chk("t2_viol", 32'(viol), 32'd0);

    // ---------------- 3: level 1 always invalid ----------------
    clear_model();
    err_n[1] = 255;
    key_tab[0] = 16'h0A0A; size_tab[0] = 16'd1;
    key_tab[2] = 16'h0C0C; size_tab[2] = 16'd3;
    resp_listsize = 4'd2;
    send_cmd(8'h22, t0);
    wait_ent(got, at, lvl, key, size);
    chk("t3_e0_at", 32'(at), 32'(t0 + 3));
    chk("t3_e0_lvl", 32'(lvl), 32'd0);
    wait_ent(got, at, lvl, key, size);
    chk("t3_e1_at", 32'(at), 32'(t0 + 29));
    chk("t3_e1_lvl", 32'(lvl), 32'd2);
    chk("t3_e1_key", 32'(key), 32'h0C0C);
    wait_done(got, at, st, cnt);
    chk("t3_done_at", 32'(at), 32'(t0 + 30));
    chk("t3_done_cnt", 32'(cnt), 32'd2);
    chk("t3_q_l1", 32'(qcnt[1]), 32'd4);
    chk("t3_q_l2", 32'(qcnt[2]), 32'd1);
    chk("t3_q_l3", 32'(qcnt[3]), 32'd0);
    chk("t3_q4_at", 32'(qcyc[4]), 32'(t0 + 25));
    chk("t3_q5_at", 32'(qcyc[5]), 32'(t0 + 27));

    // ---------------- 4: consumer stall ----------------
    clear_model();
    key_tab[0] = 16'h4444; size_tab[0] = 16'd40;
    key_tab[1] = 16'h5555; size_tab[1] = 16'd50;
    resp_listsize = 4'd2;
    i_ent_rdy = 1'b0;
    send_cmd(8'h33, t0);
    run(2);
    chk("t4_vld_T3", 32'(o_ent_vld), 32'd1);
    chk("t4_key_T3", 32'(o_ent_key), 32'h4444);
    run(10);
    chk("t4_vld_hold", 32'(o_ent_vld), 32'd1);
    chk("t4_key_hold", 32'(o_ent_key), 32'h4444);
    chk("t4_size_hold", 32'(o_ent_size), 32'd40);
    chk("t4_nq_stall", 32'(nq), 32'd1);
    chk("t4_viol", 32'(viol), 32'd0);
    i_ent_rdy = 1'b1;
    wait_ent(got, at, lvl, key, size);
    chk("t4_e0_at", 32'(at), 32'(t0 + 13));
    wait_ent(got, at, lvl, key, size);
    chk("t4_e1_at", 32'(at), 32'(t0 + 16));
    chk("t4_e1_key", 32'(key), 32'h5555);
    wait_done(got, at, st, cnt);
    chk("t4_done_at", 32'(at), 32'(t0 + 17));
    chk("t4_done_cnt", 32'(cnt), 32'd2);

    // ---------------- 5: missing response (init_r mid-walk) ----------------
    clear_model();
    key_tab[0] = 16'h6666; size_tab[0] = 16'd60;
    resp_listsize = 4'd3;
    send_cmd(8'h44, t0);
    wait_ent(got, at, lvl, key, size);
    chk("t5_e0_at", 32'(at), 32'(t0 + 3));
    suppress = 1'b1;
    init_r   = 1'b1;
    wait_done(got, at, st, cnt);
    chk("t5_done_got", 32'(got), 32'd1);
    chk("t5_done_at", 32'(at), 32'(t0 + 6));
    chk("t5_done_st", 32'(st), 32'd1);
    chk("t5_done_cnt", 32'(cnt), 32'd1);
    run(4);
    chk("t5_rdy_init", 32'(o_cmd_rdy), 32'd0);
    chk("t5_st_hold", 32'(o_done_status), 32'd1);
    init_r   = 1'b0;
    suppress = 1'b0;
    #1;
    chk("t5_rdy_after", 32'(o_cmd_rdy), 32'd1);

    // ---------------- 6: reset during backoff ----------------
    clear_model();
    err_n[0] = 255;
    resp_listsize = 4'd1;
    send_cmd(8'h77, t0);
    run(3);
    chk("t6_lut_quiet", 32'(o_lut_vld), 32'd0);
    arst_n = 1'b0;
    #1;
    chk("t6_rst_rdy", 32'(o_cmd_rdy), 32'd1);
    chk("t6_rst_id", 32'(o_lut_prod_id), 32'd0);
    chk("t6_rst_ent_key", 32'(o_ent_key), 32'd0);
    chk("t6_rst_ent_size", 32'(o_ent_size), 32'd0);
    chk("t6_rst_done_vld", 32'(o_done_vld), 32'd0);
    run(2);
    arst_n = 1'b1;
    err_n[0] = 0; key_tab[0] = 16'h7777; size_tab[0] = 16'd70;
    run(8);
    chk("t6_no_done", 32'(ndone), 32'd0);
    nq0 = nq;
    send_cmd(8'h78, t1);
    wait_ent(got, at, lvl, key, size);
    chk("t6_e_at", 32'(at), 32'(t1 + 3));
    chk("t6_e_lvl", 32'(lvl), 32'd0);
    chk("t6_e_key", 32'(key), 32'h7777);
    chk("t6_q_lvl", 32'(qlvl[nq0]), 32'd0);
    chk("t6_qid", 32'(last_id), 32'h78);
    wait_done(got, at, st, cnt);
    chk("t6_done_at", 32'(at), 32'(t1 + 4));
    chk("t6_done_cnt", 32'(cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
